mmcm_drp_ctrl: RTL

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

---
 rtl/mmcm_drp_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mmcm_drp_ctrl.sv
// -----------------------------------------------------------------------------
// mmcm_drp_ctrl
//
// Purpose:
//   Reconfigures an MMCM through its DRP port. The MMCM is held in reset while
//   every table entry gets a read-modify-write at its DRP address. The reset is
//   then released and the controller waits for lock. DRP and lock waits are
//   bounded, and a timeout raises a sticky error.
//
// Optional feature:
//   `define MMCM_DRP_VERIFY_EN  adds a readback (VFY/VFY_WAIT) after every
//   write. A mismatch aborts the sequence with o_error.
//
// Ports:
//   i_clk, i_reset_n          clock (also MMCM DCLK), async active-low reset
//   i_start                   one-cycle reconfigure request, honoured in IDLE
//   o_tbl_idx                 current table entry index
//   i_tbl_addr/mask/data      table contents at o_tbl_idx (combinational)
//   o_daddr/o_di/o_den/o_dwe  DRP master outputs
//   i_do/i_drdy               DRP read data / ready
//   o_mmcm_rst                active-high MMCM reset
//   i_locked                  MMCM lock status
//   o_busy/o_done/o_error     sequence active / success pulse / sticky failure
//   o_dbg_state               current FSM state, for debug and checkers
//
// DRP handshake:
//   Each access is a single-cycle o_den pulse (o_dwe=1 for writes). The access
//   stays outstanding until i_drdy is seen in the matching wait state, and no
//   new o_den is issued in that time. i_drdy outside a wait state is ignored.
// -----------------------------------------------------------------------------
module mmcm_drp_ctrl #(
   parameter int NUM_ENTRIES  = 8,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   output logic [3:0]  o_tbl_idx,
   input  logic [6:0]  i_tbl_addr,
   input  logic [15:0] i_tbl_mask,
   input  logic [15:0] i_tbl_data,
   output logic [6:0]  o_daddr,
   output logic [15:0] o_di,
   output logic        o_den,
   output logic        o_dwe,
   input  logic [15:0] i_do,
   input  logic        i_drdy,
   output logic        o_mmcm_rst,
   input  logic        i_locked,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [3:0]  o_dbg_state
);

   localparam int MAX_TO = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int TW     = $clog2(MAX_TO + 1);
   // A wait state decides on the cycle where cnt hits the limit. The error
   // then shows up exactly TIMEOUT cycles after the o_den pulse or reset release.
   localparam logic [TW-1:0] DRDY_LIM = TW'(DRDY_TIMEOUT - 2);
   localparam logic [TW-1:0] LOCK_LIM = TW'(LOCK_TIMEOUT - 2);
   localparam logic [3:0]    LAST_IDX = 4'(NUM_ENTRIES - 1);

   typedef enum logic [3:0] {
      IDLE,
      RST_ON,
      RD,
      RD_WAIT,
      WR,
      WR_WAIT,
`ifdef MMCM_DRP_VERIFY_EN
      VFY,
      VFY_WAIT,
`endif
      RST_OFF,
      LOCK_WAIT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic            err_q, err_d;
   logic [15:0]     rdata_q, rdata_d;
   logic [TW-1:0]   cnt_q;
   logic [15:0]     wr_val;
   logic            drdy_to, lock_to;

   // Mask bit 1 keeps the bit read back from the MMCM, 0 takes the table bit.
   assign wr_val  = (rdata_q & i_tbl_mask) | (i_tbl_data & ~i_tbl_mask);
   assign drdy_to = (cnt_q >= DRDY_LIM);
   assign lock_to = (cnt_q >= LOCK_LIM);

   assign o_tbl_idx   = idx_q;
   assign o_error     = err_q;
   assign o_dbg_state = state_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         // Restart on every state change, saturate instead of wrapping.
         if (state_d != state_q)
            cnt_q <= '0;
         else if (cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      o_daddr    = '0;
      o_di       = '0;
      o_den      = 1'b0;
      o_dwe      = 1'b0;
      o_mmcm_rst = 1'b0;
      o_done     = 1'b0;
      o_busy     = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = RST_ON;
               err_d   = 1'b0;
               idx_d   = '0;
            end
         end
         RST_ON: begin
            o_mmcm_rst = 1'b1;
            state_d    = RD;
         end
         RD: begin
            o_mmcm_rst = 1'b1;
            o_den      = 1'b1;
            o_daddr    = i_tbl_addr;
            state_d    = RD_WAIT;
         end
         RD_WAIT: begin
            o_mmcm_rst = 1'b1;
            if (i_drdy) begin
               rdata_d = i_do;
               state_d = WR;
            end else if (drdy_to) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WR: begin
            o_mmcm_rst = 1'b1;
            o_den      = 1'b1;
            o_dwe      = 1'b1;
            o_daddr    = i_tbl_addr;
            o_di       = wr_val;
            state_d    = WR_WAIT;
         end
         WR_WAIT: begin
            o_mmcm_rst = 1'b1;
            if (i_drdy) begin
`ifdef MMCM_DRP_VERIFY_EN
               state_d = VFY;
`else
               if (idx_q == LAST_IDX) begin
                  state_d = RST_OFF;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = RD;
               end
`endif
            end else if (drdy_to) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
`ifdef MMCM_DRP_VERIFY_EN
         VFY: begin
            o_mmcm_rst = 1'b1;
            o_den      = 1'b1;
            o_daddr    = i_tbl_addr;
            state_d    = VFY_WAIT;
         end
         VFY_WAIT: begin
            o_mmcm_rst = 1'b1;
            if (i_drdy) begin
               if (i_do != wr_val) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (idx_q == LAST_IDX) begin
                  state_d = RST_OFF;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = RD;
               end
            end else if (drdy_to) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         RST_OFF: begin
            state_d = LOCK_WAIT;
         end
         LOCK_WAIT: begin
            if (i_locked) begin
               state_d = DONE;
            end else if (lock_to) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
